// File: rtl/pn_spreader.sv
// rtl/pn_spreader.sv - DSSS spreader: XORs each data bit with one full PN period.
// Optional feature macro: GOLD_CODE_EN (adds a second LFSR to form a Gold code).
module pn_spreader #(
    parameter int                LFSR_W = 7,
    parameter logic [LFSR_W-1:0] TAPS_A = 7'h60,
    parameter logic [LFSR_W-1:0] SEED_A = 7'h7F,
    parameter logic [LFSR_W-1:0] TAPS_B = 7'h78,
    parameter logic [LFSR_W-1:0] SEED_B = 7'h01
) (
    input  logic clk_1m,
    input  logic rst,
    input  logic data_bit,
    input  logic data_valid,
    output logic data_ready,
    input  logic chip_en,
    output logic chip_out,
    output logic chip_valid,
    output logic epoch,
    output logic busy
);

    localparam int                PERIOD = (1 << LFSR_W) - 1;
    localparam logic [LFSR_W-1:0] LAST   = LFSR_W'(PERIOD - 1);

    typedef enum logic {IDLE, SPREAD} state_t;

    state_t            state_q;
    logic [LFSR_W-1:0] cnt_q;
    logic [LFSR_W-1:0] lfsr_a_q;
    logic [LFSR_W-1:0] lfsr_a_d;
    logic              bit_q;
    logic              chip_out_q;
    logic              chip_valid_q;
    logic              epoch_q;
    logic              last_chip;
    logic              accept;
    logic              pn;

    assign last_chip  = (state_q == SPREAD) && (cnt_q == LAST) && chip_en;
    assign data_ready = !rst && ((state_q == IDLE) || last_chip);
    assign accept     = data_valid && data_ready;
    assign lfsr_a_d   = {lfsr_a_q[LFSR_W-2:0], ^(lfsr_a_q & TAPS_A)};

`ifdef GOLD_CODE_EN
    logic [LFSR_W-1:0] lfsr_b_q;
    logic [LFSR_W-1:0] lfsr_b_d;

    assign lfsr_b_d = {lfsr_b_q[LFSR_W-2:0], ^(lfsr_b_q & TAPS_B)};
    assign pn       = lfsr_a_q[LFSR_W-1] ^ lfsr_b_q[LFSR_W-1];

    // Secondary LFSR steps in lockstep with the primary one.
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            lfsr_b_q <= SEED_B;
        end else if (accept || (lfsr_b_q == '0)) begin
            lfsr_b_q <= SEED_B;
        end else if ((state_q == SPREAD) && chip_en) begin
            lfsr_b_q <= lfsr_b_d;
        end
    end
`else
    assign pn = lfsr_a_q[LFSR_W-1];
`endif

    always_ff @(posedge clk_1m) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lfsr_a_q     <= SEED_A;
            bit_q        <= 1'b0;
            chip_out_q   <= 1'b0;
            chip_valid_q <= 1'b0;
            epoch_q      <= 1'b0;
        end else begin
            chip_valid_q <= 1'b0;
            epoch_q      <= 1'b0;
            if ((state_q == SPREAD) && chip_en) begin
                chip_out_q   <= bit_q ^ pn;
                chip_valid_q <= 1'b1;
                epoch_q      <= (cnt_q == '0);
                lfsr_a_q     <= lfsr_a_d;
                if (cnt_q == LAST) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + LFSR_W'(1);
                end
            end
            // An all-zero register would never leave zero; reseed it.
            if (lfsr_a_q == '0) begin
                lfsr_a_q <= SEED_A;
            end
            // Accept overrides the step so every bit starts at PN phase 0.
            if (accept) begin
                bit_q    <= data_bit;
                cnt_q    <= '0;
                lfsr_a_q <= SEED_A;
                state_q  <= SPREAD;
            end
        end
    end

    assign chip_out   = chip_out_q;
    assign chip_valid = chip_valid_q;
    assign epoch      = epoch_q;
    assign busy       = (state_q == SPREAD);

endmodule

// File: tb/tb_pn_spreader.sv
// tb/tb_pn_spreader.sv - scoreboard bench for pn_spreader (honours GOLD_CODE_EN).
module tb_pn_spreader;

    logic clk_1m = 1'b0;
    logic rst, data_bit, data_valid, data_ready, chip_en;
    logic chip_out, chip_valid, epoch, busy;

    always #5 clk_1m = ~clk_1m;

    pn_spreader dut (
        .clk_1m     (clk_1m),
        .rst        (rst),
        .data_bit   (data_bit),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .chip_en    (chip_en),
        .chip_out   (chip_out),
        .chip_valid (chip_valid),
        .epoch      (epoch),
        .busy       (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each entry is {chip, epoch}.
    logic [1:0] sb_q[$];

    task automatic push_bit(input logic b);
        logic [6:0] la;
        logic [6:0] lb;
        logic       pn;
        la = 7'h7F;
        lb = 7'h01;
        for (int k = 0; k < 127; k++) begin
            pn = la[6];
`ifdef GOLD_CODE_EN
            pn = pn ^ lb[6];
`endif
            sb_q.push_back({b ^ pn, (k == 0)});
            la = {la[5:0], la[6] ^ la[5]};
            lb = {lb[5:0], lb[6] ^ lb[5] ^ lb[4] ^ lb[3]};
        end
    endtask

    int         chip_cnt, ones_cnt, epoch_cnt, gaps, busy_drop, en_viol, rdy_busy;
    int         gap_tgt;
    logic [7:0] first8;
    logic       last_en = 1'b0;

    always @(negedge clk_1m) begin
        logic [1:0] e;
        if (data_valid && data_ready) push_bit(data_bit);
        if (chip_valid) begin
            if (!last_en) en_viol++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("chip", {31'd0, chip_out}, {31'd0, e[1]});
                check("epoch", {31'd0, epoch}, {31'd0, e[0]});
            end
            if (chip_cnt < 8) first8[chip_cnt] = chip_out;
            chip_cnt++;
            ones_cnt  += int'(chip_out);
            epoch_cnt += int'(epoch);
        end else if (chip_cnt > 0 && chip_cnt < gap_tgt) begin
            gaps++;
        end
        if (chip_cnt > 0 && chip_cnt < gap_tgt && !busy) busy_drop++;
        if (data_ready && busy) rdy_busy++;
        last_en = chip_en;
    end

    task automatic clr_stats(input int tgt);
        sb_q.delete();
        chip_cnt = 0; ones_cnt = 0; epoch_cnt = 0; gaps = 0;
        busy_drop = 0; en_viol = 0; rdy_busy = 0; first8 = 8'h00;
        gap_tgt = tgt;
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk_1m); #1;
        data_valid = 1'b1;
        data_bit   = b;
        @(posedge clk_1m); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_chips(input int n, input logic tog);
        int cyc = 0;
        while (chip_cnt < n && cyc < 2000) begin
            @(posedge clk_1m); #1;
            if (tog) chip_en = ~chip_en;
            cyc++;
        end
        if (chip_cnt < n) check("timeout", chip_cnt, n);
    endtask

    task automatic check_bit(input string tag, input logic b);
        check({tag, "_chips"}, chip_cnt, 127);
        check({tag, "_epochs"}, epoch_cnt, 1);
        check({tag, "_chip0"}, {31'd0, first8[0]}, {31'd0, ~b ^ 1'b0});
`ifndef GOLD_CODE_EN
        check({tag, "_first8"}, {24'd0, first8}, b ? 32'h80 : 32'h7F);
        check({tag, "_ones"}, ones_cnt, b ? 63 : 64);
`endif
    endtask

    initial begin
        logic bits [3];
        int   idx;
        logic acc;
        bits = '{1'b1, 1'b0, 1'b1};
        rst = 1'b1; data_bit = 1'b0; data_valid = 1'b0; chip_en = 1'b0;
        clr_stats(0);
        repeat (3) @(posedge clk_1m);
        @(negedge clk_1m);
        check("rst_chip_valid", {31'd0, chip_valid}, 32'd0);
        check("rst_chip_out", {31'd0, chip_out}, 32'd0);
        check("rst_epoch", {31'd0, epoch}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        @(posedge clk_1m); #1;
        rst = 1'b0;
        @(negedge clk_1m);
        check("idle_ready", {31'd0, data_ready}, 32'd1);

        // Single bit 0, then single bit 1, continuous chip_en.
        for (int t = 0; t < 2; t++) begin
            clr_stats(127);
            chip_en = 1'b1;
            send_bit(t[0]);
            wait_chips(127, 1'b0);
            repeat (3) @(posedge clk_1m);
            @(negedge clk_1m);
            check_bit(t == 0 ? "bit0" : "bit1", t[0]);
            check("single_gaps", gaps, 0);
            check("single_idle_busy", {31'd0, busy}, 32'd0);
            check("single_sb_empty", sb_q.size(), 0);
        end

        // Back-to-back bits with data_valid held high.
        clr_stats(381);
        @(posedge clk_1m); #1;
        data_valid = 1'b1;
        data_bit   = bits[0];
        idx = 0;
        for (int cyc = 0; cyc < 1000 && idx < 3; cyc++) begin
            @(negedge clk_1m);
            acc = data_valid && data_ready;
            @(posedge clk_1m); #1;
            if (acc) begin
                idx++;
                if (idx < 3) data_bit = bits[idx];
                else data_valid = 1'b0;
            end
        end
        check("b2b_accepts", idx, 3);
        wait_chips(381, 1'b0);
        repeat (3) @(posedge clk_1m);
        @(negedge clk_1m);
        check("b2b_chips", chip_cnt, 381);
        check("b2b_epochs", epoch_cnt, 3);
        check("b2b_gaps", gaps, 0);
        check("b2b_busy_drop", busy_drop, 0);
        check("b2b_ready_pulses", rdy_busy, 3);
        check("b2b_sb_empty", sb_q.size(), 0);

        // chip_en toggling every cycle.
        clr_stats(0);
        chip_en = 1'b0;
        send_bit(1'b0);
        wait_chips(127, 1'b1);
        chip_en = 1'b0;
        repeat (3) @(posedge clk_1m);
        @(negedge clk_1m);
        check_bit("tog", 1'b0);
        check("tog_en_viol", en_viol, 0);
        check("tog_sb_empty", sb_q.size(), 0);

        // Reset in the middle of a bit.
        clr_stats(0);
        chip_en = 1'b1;
        send_bit(1'b0);
        wait_chips(50, 1'b0);
        rst = 1'b1;
        @(negedge clk_1m);
        check("midrst_ready", {31'd0, data_ready}, 32'd0);
        @(posedge clk_1m); #1;
        @(negedge clk_1m);
        check("midrst_chip_valid", {31'd0, chip_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready2", {31'd0, data_ready}, 32'd0);
        @(posedge clk_1m); #1;
        rst = 1'b0;
        clr_stats(0);
        repeat (5) @(posedge clk_1m);
        @(negedge clk_1m);
        check("midrst_no_chips", chip_cnt, 0);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        send_bit(1'b0);
        wait_chips(127, 1'b0);
        repeat (3) @(posedge clk_1m);
        @(negedge clk_1m);
        check_bit("after_rst", 1'b0);
        check("after_rst_sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
